fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction fetch stage of the 16-bit MISC-V pipeline; producer side of the IF/ID interface consumed by decode.
//  Owns the PC, issues req/ack reads to instruction memory, presents {pc, ir, pc+2, valid} to IF/ID.
//  Honours stall from hazard logic; flushes and redirects on jump/new_pc. One-entry skid buffer absorbs a read returning while stalled.
// PARAMETERS
//  RESET_PC   16'h0000  PC loaded on reset
//  NOP_INSTR  16'h0000  ir_out value driven whenever valid_out=0
//  PC_STEP    2         byte increment per sequential fetch
// PORTS
//  clk          in   1   clock, all state on rising edge
//  reset        in   1   asynchronous, active-low (0 = in reset)
//  stall        in   1   decode cannot accept; hold IF/ID outputs
//  jump         in   1   redirect pulse, one cycle, from decode
//  new_pc       in   16  redirect target, valid when jump=1
//  imem_req     out  1   read request to instruction memory
//  imem_addr    out  16  read address, stable while imem_req=1
//  imem_ack     in   1   read complete, imem_rdata valid this cycle
//  imem_rdata   in   16  instruction word
//  valid_out    out  1   IF/ID payload valid
//  pc_out       out  16  PC of ir_out (to IPC)
//  ir_out       out  16  instruction (to IIR)
//  pcp2_out     out  16  pc_out + PC_STEP (to IPCP2)
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=S_IDLE, imem_req=0, imem_addr=RESET_PC, valid_out=0, ir_out=NOP_INSTR, pc_out=0, pcp2_out=0, buffer empty, discard=0.
//  Arithmetic: pc+PC_STEP modulo 2^16 (16'hFFFE -> 16'h0000); new_pc[0] forced to 0.
//  adv = !valid_out || !stall : output register may load this cycle.
//  FSM:
//   S_IDLE    -> S_REQ unconditionally (one dead cycle after reset release).
//   S_REQ     imem_req=1, imem_addr=pc latched at entry; held stable until imem_ack.
//             on ack: if adv load outputs {pc, rdata, pc+2, 1}, else load buffer -> S_FULL;
//             pc<=pc+PC_STEP; stay S_REQ (back-to-back, next req asserted next cycle).
//   S_FULL    imem_req=0; when adv: buffer -> outputs, buffer empty -> S_REQ.
//   S_DISCARD imem_req=1 held with the stale address; on ack drop rdata -> S_REQ at redirected pc.
//  Handshake: never drop imem_req or change imem_addr before imem_ack; at most one request outstanding; ack without req is ignored.
//  Fetch latency: req asserted cycle N, ack cycle N+k (k>=0 same-cycle allowed), valid_out high at N+k+1.
//  Stall: valid_out=1 && stall=1 -> all outputs frozen bit-exact.
//  Jump (priority over stall, ack, buffer drain):
//   next cycle valid_out=0, ir_out=NOP_INSTR, buffer emptied, pc=new_pc.
//   request outstanding and no ack this cycle -> S_DISCARD.
//   ack in same cycle as jump -> rdata dropped, -> S_REQ (new_pc).
//   jump in S_FULL or S_IDLE -> S_REQ.
//  Back-to-back jumps: latest new_pc wins; discard stays a single flag.
//  Reset asserted mid-transaction: everything returns to reset values immediately; any late ack is ignored (S_IDLE).
// STRUCTURE
//  Shared package misc_v_pkg: RESET_PC, NOP_INSTR, PC_STEP, fetch FSM state encoding (S_IDLE, S_REQ, S_FULL, S_DISCARD).
//  Sub-module fetch_skid_buffer: 1-entry {pc, ir} register with load/drain/flush and full flag.
//  Top holds PC register, FSM, imem interface register, IF/ID output registers.
// TESTING
//  1 Reset release, imem acks every cycle (k=0), RESET_PC=0 -> valid_out from cycle 2; pc_out 0,2,4,6; pcp2_out 2,4,6,8.
//  2 Memory latency k=3, stall=0 -> imem_addr stable 4 cycles per fetch, one valid_out pulse per ack, no addresses skipped.
//  3 stall=1 for 5 cycles while ack returns for pc=0x0008 -> outputs hold pc 0x0006, buffer holds 0x0008, imem_req=0; stall release -> 0x0008 then 0x000A.
//  4 jump new_pc=0x0100 with request for 0x0010 outstanding, ack 2 cycles later with 0xDEAD -> 0xDEAD never valid; next imem_addr=0x0100, next valid pc_out=0x0100.
//  5 jump same cycle as ack and as stall=1 -> valid_out=0, ir_out=NOP_INSTR next cycle; new_pc=0x0201 fetched as 0x0200.
//  6 pc=0xFFFE sequential fetch -> pcp2_out=0x0000, next imem_addr=0x0000; reset pulsed mid-request -> all outputs at reset values, stray ack ignored.

Source files
------------

// File: rtl/misc_v_pkg.sv
// misc_v_pkg: shared constants and fetch FSM state encoding for the MISC-V pipeline
package misc_v_pkg;

    localparam logic [15:0] RESET_PC  = 16'h0000;
    localparam logic [15:0] NOP_INSTR = 16'h0000;
    localparam logic [15:0] PC_STEP   = 16'd2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_REQ     = 2'd1,
        S_FULL    = 2'd2,
        S_DISCARD = 2'd3
    } fetch_state_e;

    // Next sequential fetch address; 16-bit wrap is intentional (0xFFFE -> 0x0000).
    function automatic logic [15:0] pc_inc(input logic [15:0] pc, input logic [15:0] step);
        return pc + step;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// fetch_skid_buffer: one-entry {pc, ir} holding register that catches a fetch returning while decode is stalled
module fetch_skid_buffer #(
    parameter logic [15:0] NOP_INSTR = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        drain,
    input  logic        flush,
    input  logic [15:0] pc_in,
    input  logic [15:0] ir_in,
    output logic        full,
    output logic [15:0] pc,
    output logic [15:0] ir
);

    logic        full_q, full_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ir_q, ir_d;

    // Flush beats load beats drain; payload only captured on a real load.
    always_comb begin
        full_d = flush ? 1'b0 : load ? 1'b1 : drain ? 1'b0 : full_q;
        pc_d   = (load && !flush) ? pc_in : pc_q;
        ir_d   = (load && !flush) ? ir_in : ir_q;
    end

    // Buffer state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            pc_q   <= 16'h0000;
            ir_q   <= NOP_INSTR;
        end else begin
            full_q <= full_d;
            pc_q   <= pc_d;
            ir_q   <= ir_d;
        end
    end

    assign full = full_q;
    assign pc   = pc_q;
    assign ir   = ir_q;

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: owns the PC, fetches over req/ack from instruction memory and feeds the IF/ID register
module fetch_stage
    import misc_v_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = misc_v_pkg::RESET_PC,
    parameter logic [15:0] NOP_INSTR = misc_v_pkg::NOP_INSTR,
    parameter logic [15:0] PC_STEP   = misc_v_pkg::PC_STEP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        jump,
    input  logic [15:0] new_pc,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        valid_out,
    output logic [15:0] pc_out,
    output logic [15:0] ir_out,
    output logic [15:0] pcp2_out
);

    fetch_state_e state_q, state_d;
    logic [15:0]  pc_q, pc_d;
    logic [15:0]  addr_q, addr_d;
    logic         valid_q, valid_d;
    logic [15:0]  pc_out_q, pc_out_d;
    logic [15:0]  ir_q, ir_d;
    logic [15:0]  pcp2_q, pcp2_d;

    logic         ack_v;
    logic         adv;
    logic         fetch_ok;
    logic         buf_load;
    logic         buf_drain;
    logic         buf_full;
    logic [15:0]  buf_pc;
    logic [15:0]  buf_ir;

    // An ack only counts while a request is actually outstanding.
    assign imem_req  = (state_q == S_REQ) || (state_q == S_DISCARD);
    assign ack_v     = imem_ack && imem_req;
    assign adv       = !valid_q || !stall;
    assign fetch_ok  = (state_q == S_REQ) && ack_v;
    assign buf_load  = !jump && fetch_ok && !adv;
    assign buf_drain = !jump && buf_full && adv;

    fetch_skid_buffer #(
        .NOP_INSTR(NOP_INSTR)
    ) u_skid (
        .clk   (clk),
        .reset (reset),
        .load  (buf_load),
        .drain (buf_drain),
        .flush (jump),
        .pc_in (pc_q),
        .ir_in (imem_rdata),
        .full  (buf_full),
        .pc    (buf_pc),
        .ir    (buf_ir)
    );

    // Fetch FSM next state, PC and request address; the address only stays stale while discarding.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    state_d = S_REQ;
            S_REQ:     state_d = jump ? (ack_v ? S_REQ : S_DISCARD)
                                      : ((ack_v && !adv) ? S_FULL : S_REQ);
            S_FULL:    state_d = (jump || adv) ? S_REQ : S_FULL;
            S_DISCARD: state_d = ack_v ? S_REQ : S_DISCARD;
            default:   state_d = S_IDLE;
        endcase
        pc_d   = jump ? (new_pc & ~16'h0001) : fetch_ok ? pc_inc(pc_q, PC_STEP) : pc_q;
        addr_d = (state_d == S_DISCARD) ? addr_q : pc_d;
    end

    // IF/ID payload: jump kills it, otherwise load fresh data, then buffered data, else go empty; hold on stall.
    always_comb begin
        valid_d  = valid_q;
        pc_out_d = pc_out_q;
        ir_d     = ir_q;
        pcp2_d   = pcp2_q;
        if (jump) begin
            valid_d = 1'b0;
            ir_d    = NOP_INSTR;
        end else if (adv && fetch_ok) begin
            valid_d  = 1'b1;
            pc_out_d = pc_q;
            ir_d     = imem_rdata;
            pcp2_d   = pc_inc(pc_q, PC_STEP);
        end else if (adv && buf_full) begin
            valid_d  = 1'b1;
            pc_out_d = buf_pc;
            ir_d     = buf_ir;
            pcp2_d   = pc_inc(buf_pc, PC_STEP);
        end else if (adv) begin
            valid_d = 1'b0;
            ir_d    = NOP_INSTR;
        end
    end

    // State, PC, memory interface and IF/ID registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            valid_q  <= 1'b0;
            pc_out_q <= 16'h0000;
            ir_q     <= NOP_INSTR;
            pcp2_q   <= 16'h0000;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            valid_q  <= valid_d;
            pc_out_q <= pc_out_d;
            ir_q     <= ir_d;
            pcp2_q   <= pcp2_d;
        end
    end

    assign imem_addr = addr_q;
    assign valid_out = valid_q;
    assign pc_out    = pc_out_q;
    assign ir_out    = ir_q;
    assign pcp2_out  = pcp2_q;

endmodule
